svv_push_arbiter: RTL and testbench

- Shares one status value vector (push / pull / set-last-entry FIFO, DEPTH x WIDTH) between NUM_REQ producers and one consumer.
- Round-robin arbitration decides which producer may push each cycle. Pushes are throttled against a local occupancy mirror, so the vector never sees a push it would drop.
- Tracks which producer owns the tail (newest) entry. Only that producer may re-update the tail through the set path.
- Sits directly in front of the vector; vector outputs value/valid go straight to the consumer.

---
 rtl/svv_pkg.sv | 19 +
 rtl/svv_rr_arbiter.sv | 40 ++++
 rtl/svv_push_arbiter.sv | 112 +++++++++++
 tb/tb_svv_push_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/svv_pkg.sv
// Shared defaults and sizing helpers for the status-value-vector front end.
package svv_pkg;

    localparam int unsigned SVV_DEPTH = 8;
    localparam int unsigned SVV_WIDTH = 8;

    // Ceiling log2, returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned SVV_CNT_W = clog2(SVV_DEPTH) + 1;

endpackage

// File: rtl/svv_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, with wrap.
module svv_rr_arbiter
    import svv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int unsigned ID_W = clog2(NUM_REQ);

    logic              w_found;
    logic [ID_W-1:0]   w_cand;
    int unsigned       w_sum;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        w_sum   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = 32'(ptr_i) + i;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_cand = ID_W'(w_sum);
            if (en_i && !w_found && req_i[w_cand]) begin
                w_found         = 1'b1;
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
            end
        end
    end

endmodule

// File: rtl/svv_push_arbiter.sv
// Round-robin push arbitration, occupancy mirror and tail-ownership gating in
// front of a shared status value vector.
module svv_push_arbiter
    import svv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = SVV_DEPTH,
    parameter int unsigned WIDTH   = SVV_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic [NUM_REQ-1:0]         req_push_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_value_i,
    output logic [NUM_REQ-1:0]         req_grant_o,
    input  logic [NUM_REQ-1:0]         req_set_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_set_value_i,
    output logic [NUM_REQ-1:0]         req_set_ack_o,
    input  logic                       cons_pull_i,
    output logic                       svv_push_o,
    output logic [WIDTH-1:0]           svv_value_o,
    output logic                       svv_pull_o,
    output logic                       svv_set_o,
    output logic [WIDTH-1:0]           svv_set_value_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_id_o,
    output logic                       owner_valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned ID_W  = clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_tail_owner;
    logic               r_tail_valid;
    logic [CNT_W-1:0]   r_count;

    logic [CNT_W-1:0]   w_count_next;
    logic               w_pull;
    logic               w_push_ok;
    logic               w_push;
    logic               w_set_ok;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_ack;
    logic [WIDTH-1:0]   w_value;
    logic [WIDTH-1:0]   w_set_value;

    // A pull frees a slot in the same cycle, so a full vector may still accept a push.
    assign w_pull    = rsn_i & cons_pull_i & (r_count != '0);
    assign w_push_ok = (r_count < CNT_W'(DEPTH)) | w_pull;

    svv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_push_i),
        .en_i    (rsn_i & w_push_ok),
        .ptr_i   (r_rr_ptr),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    assign w_push   = |w_grant;
    assign w_set_ok = rsn_i & r_tail_valid & req_set_i[r_tail_owner];

    // Value muxing for the granted pusher and the tail owner's set.
    always_comb begin
        w_value     = '0;
        w_set_value = '0;
        w_ack       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_value = req_value_i[k*WIDTH +: WIDTH];
            end
            if (w_set_ok && (r_tail_owner == ID_W'(k))) begin
                w_set_value = req_set_value_i[k*WIDTH +: WIDTH];
                w_ack[k]    = 1'b1;
            end
        end
    end

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pull);

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_tail_owner <= '0;
            r_tail_valid <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_rr_ptr     <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
                r_tail_owner <= w_idx;
                r_tail_valid <= 1'b1;
            end else if (w_count_next == '0) begin
                r_tail_valid <= 1'b0;
            end
        end
    end

    assign req_grant_o     = w_grant;
    assign req_set_ack_o   = w_ack;
    assign svv_push_o      = w_push;
    assign svv_value_o     = w_value;
    assign svv_pull_o      = w_pull;
    assign svv_set_o       = w_set_ok;
    assign svv_set_value_o = w_set_value;
    assign owner_id_o      = r_tail_owner;
    assign owner_valid_o   = r_tail_valid;
    assign count_o         = r_count;

endmodule

// File: tb/tb_svv_push_arbiter.sv
// Directed scoreboard bench for svv_push_arbiter (NUM_REQ=4, DEPTH=8, WIDTH=8).
module tb_svv_push_arbiter;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic [3:0]  req_push_i;
    logic [31:0] req_value_i;
    logic [3:0]  req_grant_o;
    logic [3:0]  req_set_i;
    logic [31:0] req_set_value_i;
    logic [3:0]  req_set_ack_o;
    logic        cons_pull_i;
    logic        svv_push_o;
    logic [7:0]  svv_value_o;
    logic        svv_pull_o;
    logic        svv_set_o;
    logic [7:0]  svv_set_value_o;
    logic [1:0]  owner_id_o;
    logic        owner_valid_o;
    logic [3:0]  count_o;

    typedef struct packed {
        logic [3:0] grant;
        logic       push;
        logic [7:0] value;
        logic       pull;
        logic [3:0] ack;
        logic       set;
        logic [7:0] set_value;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] PV = 32'h13121110;

    svv_push_arbiter #(.NUM_REQ(4), .DEPTH(8), .WIDTH(8)) dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .req_push_i      (req_push_i),
        .req_value_i     (req_value_i),
        .req_grant_o     (req_grant_o),
        .req_set_i       (req_set_i),
        .req_set_value_i (req_set_value_i),
        .req_set_ack_o   (req_set_ack_o),
        .cons_pull_i     (cons_pull_i),
        .svv_push_o      (svv_push_o),
        .svv_value_o     (svv_value_o),
        .svv_pull_o      (svv_pull_o),
        .svv_set_o       (svv_set_o),
        .svv_set_value_o (svv_set_value_o),
        .owner_id_o      (owner_id_o),
        .owner_valid_o   (owner_valid_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, queue expectation, compare combinational outputs at negedge.
    task automatic step(input string tag,
                        input logic [3:0] p, input logic [31:0] pv,
                        input logic [3:0] s, input logic [31:0] sv,
                        input logic pl,
                        input logic [3:0] eg, input logic [7:0] ev, input logic epl,
                        input logic [3:0] ea, input logic [7:0] esv);
        exp_t e;
        req_push_i      = p;
        req_value_i     = pv;
        req_set_i       = s;
        req_set_value_i = sv;
        cons_pull_i     = pl;
        e.grant = eg; e.push = |eg; e.value = ev; e.pull = epl;
        e.ack = ea; e.set = |ea; e.set_value = esv;
        sb_q.push_back(e);
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".grant"},     32'(req_grant_o),     32'(e.grant));
            chk({tag, ".push"},      32'(svv_push_o),      32'(e.push));
            chk({tag, ".value"},     32'(svv_value_o),     32'(e.value));
            chk({tag, ".pull"},      32'(svv_pull_o),      32'(e.pull));
            chk({tag, ".ack"},       32'(req_set_ack_o),   32'(e.ack));
            chk({tag, ".set"},       32'(svv_set_o),       32'(e.set));
            chk({tag, ".set_value"}, 32'(svv_set_value_o), 32'(e.set_value));
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt,
                             input logic [1:0] oid, input logic oval);
        chk({tag, ".count"},       32'(count_o),       32'(cnt));
        chk({tag, ".owner_valid"}, 32'(owner_valid_o), 32'(oval));
        if (oval) chk({tag, ".owner_id"}, 32'(owner_id_o), 32'(oid));
    endtask

    initial begin
        rsn_i = 1'b0;
        req_push_i = '0; req_value_i = '0; req_set_i = '0; req_set_value_i = '0; cons_pull_i = 1'b0;

        // Reset: all combinational outputs forced low despite active requests
        step("rst", 4'hF, PV, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
        chk_state("rst", 4'd0, 2'd0, 1'b0);
        chk("rst.owner_id", 32'(owner_id_o), 32'd0);
        rsn_i = 1'b1;

        // Contention: strict round-robin 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            step("contend", 4'hF, PV, 4'h0, 32'h0, 1'b0,
                 4'(1 << (i % 4)), 8'(8'h10 + i % 4), 1'b0, 4'h0, 8'h00);
        end
        chk_state("contend", 4'd8, 2'd3, 1'b1);
        step("full_nopull", 4'hF, PV, 4'h0, 32'h0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

        // Full throttle: push only alongside a pull
        step("full_p2", 4'h4, PV, 4'h0, 32'h0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
        step("full_p2_pull", 4'h4, PV, 4'h0, 32'h0, 1'b1, 4'h4, 8'h12, 1'b1, 4'h0, 8'h00);
        chk_state("full_swap", 4'd8, 2'd2, 1'b1);

        // Drain to empty
        for (int i = 0; i < 8; i++) begin
            step("drain", 4'h0, PV, 4'h0, 32'h0, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00);
        end
        chk_state("drained", 4'd0, 2'd0, 1'b0);

        // Empty pull and sets with no tail: nothing forwarded
        step("empty", 4'h0, PV, 4'hF, 32'h5555_5555, 1'b1, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
        chk_state("empty", 4'd0, 2'd0, 1'b0);

        // Owner-only set (rr_ptr=3, only producer 1 requests)
        step("own_push", 4'h2, 32'h0000_2200, 4'h0, 32'h0, 1'b0, 4'h2, 8'h22, 1'b0, 4'h0, 8'h00);
        chk_state("own_push", 4'd1, 2'd1, 1'b1);
        step("own_set", 4'h0, PV, 4'h3, 32'h0000_5550, 1'b0, 4'h0, 8'h00, 1'b0, 4'h2, 8'h55);

        // Set to old tail owner while producer 3 pushes
        step("set_push", 4'h8, 32'h8800_0000, 4'h2, 32'h0000_7700, 1'b0, 4'h8, 8'h88, 1'b0, 4'h2, 8'h77);
        chk_state("set_push", 4'd2, 2'd3, 1'b1);
        step("stale_set", 4'h0, PV, 4'h2, 32'h0000_6600, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

        // Set + pull on the last entry
        step("pull1", 4'h0, PV, 4'h0, 32'h0, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00);
        chk_state("pull1", 4'd1, 2'd3, 1'b1);
        step("set_pull", 4'h0, PV, 4'h8, 32'h9900_0000, 1'b1, 4'h0, 8'h00, 1'b1, 4'h8, 8'h99);
        chk_state("set_pull", 4'd0, 2'd0, 1'b0);

        // Refill, then set + push + pull while full
        for (int i = 0; i < 8; i++) begin
            step("refill", 4'hF, PV, 4'h0, 32'h0, 1'b0,
                 4'(1 << (i % 4)), 8'(8'h10 + i % 4), 1'b0, 4'h0, 8'h00);
        end
        chk_state("refill", 4'd8, 2'd3, 1'b1);
        step("triple", 4'h1, PV, 4'h8, 32'hAA00_0000, 1'b1, 4'h1, 8'h10, 1'b1, 4'h8, 8'hAA);
        chk_state("triple", 4'd8, 2'd0, 1'b1);

        // Down to 5, then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            step("to5", 4'h0, PV, 4'h0, 32'h0, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00);
        end
        chk_state("to5", 4'd5, 2'd0, 1'b1);
        rsn_i = 1'b0;
        step("mid_rst", 4'hF, PV, 4'h1, 32'h0000_00EE, 1'b1, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
        rsn_i = 1'b1;
        chk_state("post_rst", 4'd0, 2'd0, 1'b0);
        step("post_rst", 4'hF, PV, 4'h0, 32'h0, 1'b0, 4'h1, 8'h10, 1'b0, 4'h0, 8'h00);
        chk_state("post_rst", 4'd1, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
